// File: rtl/result_flags_pipe.sv
// Result-flags pipeline: delays each instruction's flag-update class by STAGES
// cycles and merges the execution-unit flags into the architectural register.
module result_flags_pipe #(
  parameter int unsigned FLAG_W = 4,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [2:0]        issue_class,
  input  logic [3:0]        result_flags,
  input  logic              flags_wr,
  input  logic [FLAG_W-1:0] flags_wr_data,
  output logic [FLAG_W-1:0] flags,
  output logic [FLAG_W-1:0] flags_next,
  output logic [2:0]        commit_class,
  output logic              pending,
  output logic [CNT_W-1:0]  pending_cnt
);

  typedef enum logic [2:0] {
    CLS_NO_OP        = 3'd0,
    CLS_LOAD_ARITH   = 3'd1,
    CLS_LOAD_ARITH_O = 3'd2,
    CLS_LOAD_LOGIC   = 3'd3,
    CLS_LOAD_MULT    = 3'd4,
    CLS_LOAD_SHIFT   = 3'd5
  } cls_e;

  logic [STAGES-1:0] r_vld;
  cls_e              r_cls [STAGES];
  logic [FLAG_W-1:0] r_flags;

  logic              w_issue_ok;
  logic              w_exit_vld;
  cls_e              w_exit_cls;
  logic [FLAG_W-1:0] w_merge;
  logic [FLAG_W-1:0] w_flags_next;
  logic [CNT_W-1:0]  w_cnt;

  // Reserved classes 6-7 fall outside the range and are stored as invalid NO_OPs.
  assign w_issue_ok = issue_valid && (issue_class >= 3'd1) && (issue_class <= 3'd5);
  assign w_exit_vld = r_vld[STAGES-1];
  assign w_exit_cls = r_cls[STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld   <= '0;
      r_flags <= '0;
      for (int unsigned i = 0; i < STAGES; i++) r_cls[i] <= CLS_NO_OP;
    end else if (enable) begin
      r_flags <= w_flags_next;
      if (flush) begin
        r_vld <= '0;
        for (int unsigned i = 0; i < STAGES; i++) r_cls[i] <= CLS_NO_OP;
      end else begin
        r_vld[0] <= w_issue_ok;
        r_cls[0] <= w_issue_ok ? cls_e'(issue_class) : CLS_NO_OP;
        for (int unsigned i = 1; i < STAGES; i++) begin
          r_vld[i] <= r_vld[i-1];
          r_cls[i] <= r_cls[i-1];
        end
      end
    end
  end

  // Bit order is {O,N,Z,C}; bits above O are only touched by an explicit write.
  always_comb begin
    w_merge = r_flags;
    case (w_exit_cls)
      CLS_LOAD_ARITH, CLS_LOAD_SHIFT: w_merge[2:0] = result_flags[2:0];
      CLS_LOAD_ARITH_O:               w_merge[3:0] = result_flags;
      CLS_LOAD_LOGIC: begin
        w_merge[0]   = 1'b0;
        w_merge[2:1] = result_flags[2:1];
        w_merge[3]   = 1'b0;
      end
      CLS_LOAD_MULT: begin
        w_merge[0]   = result_flags[3];
        w_merge[3:1] = result_flags[3:1];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_flags_next = r_flags;
    if (enable && flags_wr) w_flags_next = flags_wr_data;
    else if (w_exit_vld)    w_flags_next = w_merge;
  end

  always_comb begin
    w_cnt = '0;
    for (int unsigned i = 0; i < STAGES; i++) w_cnt = w_cnt + CNT_W'(r_vld[i]);
  end

  assign flags        = r_flags;
  assign flags_next   = w_flags_next;
  assign commit_class = w_exit_vld ? w_exit_cls : CLS_NO_OP;
  assign pending_cnt  = w_cnt;
  assign pending      = (w_cnt != '0);

endmodule

// File: doc/result_flags_pipe.md
Name: result_flags_pipe

Overview:
- Parametrised successor to the single-cycle result-flags control register.
- Accepts a flag-update class per issued instruction and carries it through a STAGES-deep delay line to stay aligned with the ALU/multiplier/shifter result.
- On exit, applies a per-class update mask to the architectural flags register.
- Adds stall, flush, explicit flag write (interrupt return/restore), an in-flight scoreboard for flag consumers, and a forwarded next-flags view.

Parameters:
- FLAG_W, 4, architectural flags width; minimum 4; bit0=C, bit1=Z, bit2=N, bit3=O; bits above 3 are changed only by explicit write.
- STAGES, 2, cycles from issue to result-flag availability; minimum 1.
- CNT_W, $clog2(STAGES+1), width of the in-flight count.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1=advance; 0=stall: pipeline, commit and explicit write all frozen
- flush  in  1  kill all in-flight entries
- issue_valid  in  1  instruction entering EXECUTE0
- issue_class  in  3  0 NO_OP, 1 LOAD_ARITH, 2 LOAD_ARITH_O, 3 LOAD_LOGIC, 4 LOAD_MULT, 5 LOAD_SHIFT; 6-7 treated as NO_OP
- result_flags  in  4  {O,N,Z,C} from the execution units, valid in the cycle the matching entry exits
- flags_wr  in  1  explicit full write
- flags_wr_data  in  FLAG_W  value for the explicit write
- flags  out  FLAG_W  architectural flags (registered)
- flags_next  out  FLAG_W  combinational value flags will take at the next enabled edge
- commit_class  out  3  class of the entry exiting this cycle; NO_OP if none
- pending  out  1  any valid flag-updating entry in flight
- pending_cnt  out  CNT_W  number of valid non-NO_OP entries in flight

Behaviour:
- Reset (sync, highest priority over enable and flush):
  - flags=0.
  - All stage valids=0, all stage classes=NO_OP.
  - commit_class=NO_OP, pending=0, pending_cnt=0.
- Delay line, on an enabled edge:
  - stage0 <= {issue_valid && class in 1..5, class}.
  - stage[i] <= stage[i-1].
  - Entries with NO_OP or a reserved class are stored as invalid.
- Exit entry = stage[STAGES-1]. commit_class = its class if valid, else NO_OP.
- Update mask applied at exit (r = result_flags):
  - LOAD_ARITH: C,Z,N <= r; O held.
  - LOAD_ARITH_O: C,Z,N,O <= r.
  - LOAD_LOGIC: Z,N <= r; C <= 0; O <= 0.
  - LOAD_MULT: Z,N,O <= r; C <= r.O.
  - LOAD_SHIFT: C,Z,N <= r; O held.
- flags_next priority:
  1. flags_wr → flags_wr_data (the exiting entry is consumed and discarded).
  2. Else a valid exit entry → masked merge.
  3. Else flags.
- flags <= flags_next on enabled edges only.
- enable=0:
  - All state holds, including flags.
  - flags_wr is ignored and must be held by the source.
  - flags_next still reflects the pending merge.
- flush=1 on an enabled edge:
  - All stage valids cleared.
  - issue_valid in the same cycle is dropped.
  - The exit entry in that cycle still commits: it is already architectural.
- flush=1 with enable=0: flush is ignored; the source holds it.
- pending_cnt is the population count of valid stages, computed combinationally from the stage registers. pending = (pending_cnt != 0).
- STAGES=1: the exit entry is the one issued on the previous enabled edge.
- Back-to-back issues each commit in order, one per cycle; the last writer wins per bit.
- Reset asserted mid-stream discards all in-flight entries; no partial commit occurs on the reset edge.

Test Plan:
- Reset, then ADD (class 2), STAGES=2, result_flags=4'b1011 two enabled cycles later → flags=4'b1011 on the next edge; pending=1 for exactly 2 cycles; commit_class=2 in the exit cycle.
- flags=4'b1000, LOAD_ARITH with r=4'b0101 → flags=4'b1101 (O held); then LOAD_LOGIC with r=4'b1111 → flags=4'b0110.
- LOAD_MULT with r=4'b1000 → C=1, O=1, Z=0, N=0; flags=4'b1001.
- Issue three back-to-back LOAD_SHIFT; enable=0 for 3 cycles mid-stream → pending_cnt and flags frozen; after release all three commit in order; final flags equal the third result.
- Two entries in flight, flush=1 in the exit cycle of the first → first commits, second never commits; pending_cnt=0 next cycle.
- flags_wr=1, flags_wr_data=4'b0110 in the same cycle as an ARITH_O exit with r=4'b1111 → flags=4'b0110. Repeat with enable=0 → flags unchanged.
